// File: rtl/add8u_err_pkg.sv
// Shared types and width helpers for the approximate-adder error meter.
package add8u_err_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, FIN} state_t;

    // Index spans every (A,B) pair.
    function automatic int unsigned idx_width(input int unsigned w);
        return 2 * w;
    endfunction

    // Up to 2^(2W) mismatching pairs.
    function automatic int unsigned cnt_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // 2^(2W) samples of |d| < 2^(W+1).
    function automatic int unsigned abs_width(input int unsigned w);
        return 3 * w + 2;
    endfunction

    // 2^(2W) samples of d^2 < 2^(2W+2).
    function automatic int unsigned sq_width(input int unsigned w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/err_dly_line.sv
// Fixed-depth {valid,data} shift register; DEPTH=0 degenerates to a wire.
module err_dly_line #(
    parameter int unsigned DW    = 9,
    parameter int unsigned DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid;
            assign out_data       = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0][DW:0] stage;

            always_ff @(posedge clk) begin
                if (rst) stage[0] <= '0;
                else     stage[0] <= {in_valid, in_data};
            end

            for (genvar i = 1; i < DEPTH; i++) begin : g_stage
                always_ff @(posedge clk) begin
                    if (rst) stage[i] <= '0;
                    else     stage[i] <= stage[i-1];
                end
            end

            assign {out_valid, out_data} = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/add8u_err_meter.sv
// Exhaustive operand sweeper that scores an approximate adder against the exact sum.
module add8u_err_meter
    import add8u_err_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PIPE_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              dut_a,
    output logic [WIDTH-1:0]              dut_b,
    input  logic [WIDTH:0]                dut_o,
    output logic [cnt_width(WIDTH)-1:0]   err_cnt,
    output logic [abs_width(WIDTH)-1:0]   sum_abs_err,
    output logic [WIDTH:0]                wce,
    output logic [sq_width(WIDTH)-1:0]    sum_sq_err
);

    localparam int unsigned IW  = idx_width(WIDTH);
    localparam int unsigned OW  = WIDTH + 1;
    localparam int unsigned DFW = WIDTH + 2;
    localparam int unsigned QW  = 2 * OW;
    localparam int unsigned CW  = cnt_width(WIDTH);
    localparam int unsigned AW  = abs_width(WIDTH);
    localparam int unsigned SW  = sq_width(WIDTH);
    localparam int unsigned DCW = $clog2(PIPE_LAT + 1) + 1;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt_c;
    logic [DCW-1:0]  drain_cnt;
    logic            sweep_c;
    logic [OW-1:0]   exact_c;
    logic            smp_valid;
    logic [OW-1:0]   smp_exact;
    logic signed [DFW-1:0] diff_c;
    logic [OW-1:0]   abs_c;
    logic [QW-1:0]   sq_c;

    assign idx_nxt_c = idx + IW'(1);
    assign sweep_c   = (state == SWEEP);
    assign exact_c   = OW'(dut_a) + OW'(dut_b);

    // Exact reference follows the adder's latency so it lines up with dut_o.
    err_dly_line #(.DW(OW), .DEPTH(PIPE_LAT)) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sweep_c),
        .in_data   (exact_c),
        .out_valid (smp_valid),
        .out_data  (smp_exact)
    );

    assign diff_c = $signed({1'b0, dut_o}) - $signed({1'b0, smp_exact});
    assign abs_c  = diff_c[DFW-1] ? OW'(-diff_c) : OW'(diff_c);
    assign sq_c   = QW'(abs_c) * QW'(abs_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dut_a       <= '0;
            dut_b       <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            wce         <= '0;
            sum_sq_err  <= '0;
        end else begin
            done <= 1'b0;

            if (smp_valid) begin
                err_cnt     <= err_cnt + CW'(diff_c != '0);
                sum_abs_err <= sum_abs_err + AW'(abs_c);
                sum_sq_err  <= sum_sq_err + SW'(sq_c);
                if (abs_c > wce) wce <= abs_c;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SWEEP;
                        idx         <= '0;
                        dut_a       <= '0;
                        dut_b       <= '0;
                        busy        <= 1'b1;
                        err_cnt     <= '0;
                        sum_abs_err <= '0;
                        wce         <= '0;
                        sum_sq_err  <= '0;
                    end
                end
                SWEEP: begin
                    idx <= idx_nxt_c;
                    if (idx == '1) begin
                        drain_cnt <= '0;
                        if (PIPE_LAT == 0) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        dut_a <= idx_nxt_c[WIDTH-1:0];
                        dut_b <= idx_nxt_c[IW-1:WIDTH];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DCW'(PIPE_LAT - 1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    dut_a <= '0;
                    dut_b <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
